frame_dma_reader: RTL and testbench

Avalon-MM read master that streams a block of 32-bit words out of SDRAM into a ready/valid stream. Sits directly downstream of the `soc` system's `export_start_new_signal` / `export_size_new_signal` PIO exports, which supply the base address and word count. Read requests go back into the SDRAM controller through an MM bridge port. Words emerge in address order for the pixel/raster consumer.

---
 rtl/frame_dma_reader.sv | 152 +++++++++++++++
 tb/tb_frame_dma_reader.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_dma_reader.sv
// Avalon-MM read master: streams size_words 32-bit words from start_addr into a ready/valid stream.
// Optional continuous frame scan-out when FRAME_DMA_LOOP_EN is defined.
module frame_dma_reader #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic [31:0]       start_addr,
  input  logic [31:0]       size_words,
  input  logic              go,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  output logic [31:0]       st_data,
  output logic              st_valid,
  input  logic              st_ready
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       remaining_q, remaining_d;
  logic [CntW-1:0]   outstanding_q, outstanding_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic              done_q, done_d;
  logic [31:0]       mem_q [FIFO_DEPTH];

  logic [31:0]       start_aligned;
  logic [CntW:0]     credit_used;
  logic              accept;
  logic              push;
  logic              pop;

  assign start_aligned = start_addr & 32'hFFFF_FFFC;
  // Credit covers both buffered words and reads still in flight, so a push never finds it full.
  assign credit_used   = {1'b0, count_q} + {1'b0, outstanding_q};
  assign avm_read      = (state_q == StRead) && (remaining_q != 32'd0) &&
                         (credit_used < (CntW + 1)'(FIFO_DEPTH));
  assign accept        = avm_read & ~avm_waitrequest;
  // Returns with nothing outstanding are leftovers from before a reset.
  assign push          = avm_readdatavalid && (outstanding_q != '0);
  assign st_valid      = (count_q != '0);
  assign pop           = st_valid & st_ready;
  assign st_data       = st_valid ? mem_q[rd_ptr_q] : 32'd0;
  assign avm_address   = addr_q;
  assign busy          = (state_q != StIdle);
  assign done          = done_q;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    remaining_d   = remaining_q;
    outstanding_d = outstanding_q;
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    done_d        = 1'b0;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    unique case ({accept, push})
      2'b10:   outstanding_d = outstanding_q + 1'b1;
      2'b01:   outstanding_d = outstanding_q - 1'b1;
      default: outstanding_d = outstanding_q;
    endcase

    if (accept) begin
      addr_d      = addr_q + ADDR_W'(4);
      remaining_d = remaining_q - 32'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (go) begin
          if (size_words != 32'd0) begin
            state_d     = StRead;
            addr_d      = ADDR_W'(start_aligned);
            remaining_d = size_words;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StRead: begin
        if (accept && (remaining_q == 32'd1)) state_d = StDrain;
      end
      StDrain: begin
        if ((outstanding_q == '0) && (count_q == CntW'(1)) && pop) begin
          done_d = 1'b1;
`ifdef FRAME_DMA_LOOP_EN
          if (size_words != 32'd0) begin
            state_d     = StRead;
            addr_d      = ADDR_W'(start_aligned);
            remaining_d = size_words;
          end else begin
            state_d = StIdle;
          end
`else
          state_d = StIdle;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      remaining_q   <= '0;
      outstanding_q <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      remaining_q   <= remaining_d;
      outstanding_q <= outstanding_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      done_q        <= done_d;
    end
  end

  // Storage needs no reset: st_data is masked until an entry is valid.
  always_ff @(posedge clk_clk) begin
    if (push) mem_q[wr_ptr_q] <= avm_readdata;
  end

endmodule

// File: tb/tb_frame_dma_reader.sv
// Directed bench for frame_dma_reader with an in-order Avalon slave model (configurable
// latency and waitrequest stalls).
module tb_frame_dma_reader;

  logic        clk_clk = 1'b0;
  logic        reset_reset;
  logic [31:0] start_addr;
  logic [31:0] size_words;
  logic        go;
  logic        busy;
  logic        done;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;
  logic [31:0] st_data;
  logic        st_valid;
  logic        st_ready;

  int checks   = 0;
  int failures = 0;

  frame_dma_reader #(.FIFO_DEPTH(16), .ADDR_W(32)) dut (
    .clk_clk           (clk_clk),
    .reset_reset       (reset_reset),
    .start_addr        (start_addr),
    .size_words        (size_words),
    .go                (go),
    .busy              (busy),
    .done              (done),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .st_data           (st_data),
    .st_valid          (st_valid),
    .st_ready          (st_ready)
  );

  always #5 clk_clk = ~clk_clk;

  // Slave model: pipe stage lat_sel carries the return (lat_sel = latency - 1).
  logic [2:0]  lat_sel   = 3'd1;
  int unsigned ws        = 0;
  int unsigned stall_cnt = 0;
  logic [7:0]  pv        = 8'd0;
  logic [31:0] pa [8];

  assign avm_waitrequest   = avm_read && (stall_cnt != ws);
  assign avm_readdatavalid = pv[lat_sel];
  assign avm_readdata      = pv[lat_sel] ? (pa[lat_sel] ^ 32'hDEAD_0000) : 32'd0;

  always @(posedge clk_clk) begin
    if (avm_read && avm_waitrequest) stall_cnt <= stall_cnt + 1;
    else if (avm_read)               stall_cnt <= 0;
    pv    <= {pv[6:0], avm_read & ~avm_waitrequest};
    pa[0] <= avm_address;
    for (int i = 1; i < 8; i++) pa[i] <= pa[i-1];
  end

  function automatic logic [31:0] exp_data(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  // Monitor: records what crosses each clock edge.
  logic [31:0] acc_q [$];
  logic [31:0] pop_q [$];
  int          cyc           = 0;
  int          n_done        = 0;
  int          done_cyc      = 0;
  int          go_cyc        = 0;
  int          first_rdv_cyc = -1;
  int          first_vld_cyc = -1;
  int          stable_err    = 0;
  int          done_busy_err = 0;
  int          busy_low      = 0;
  int          vld_cnt       = 0;
  int          n_rdv         = 0;
  logic        prev_stall    = 1'b0;
  logic [31:0] prev_addr     = 32'd0;

  always @(posedge clk_clk) begin
    if (avm_read & ~avm_waitrequest) acc_q.push_back(avm_address);
    if (st_valid & st_ready) pop_q.push_back(st_data);
    if (done) begin
      n_done++;
      done_cyc = cyc;
      if (busy) done_busy_err++;
    end
    if (go) go_cyc = cyc;
    if (avm_readdatavalid) begin
      n_rdv++;
      if (first_rdv_cyc < 0) first_rdv_cyc = cyc;
    end
    if (st_valid) begin
      vld_cnt++;
      if (first_vld_cyc < 0) first_vld_cyc = cyc;
    end
    if (prev_stall && (!avm_read || (avm_address != prev_addr))) stable_err++;
    prev_stall = avm_read & avm_waitrequest;
    prev_addr  = avm_address;
    if (!busy) busy_low++;
    cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_clk);
      #1;
    end
  endtask

  task automatic pulse_go(input logic [31:0] a, input logic [31:0] s);
    start_addr = a;
    size_words = s;
    go         = 1'b1;
    tick(1);
    go         = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int base, input int limit);
    int k = 0;
    while ((n_done == base) && (k < limit)) begin
      tick(1);
      k++;
    end
    chk(tag, 32'(n_done > base), 32'd1);
  endtask

  // Counts mismatches of a run of n accepted addresses and popped words against a linear sweep.
  function automatic int sweep_err(input int ab, input int pb, input logic [31:0] a0, input int n);
    int e = 0;
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      a = a0 + 32'(4 * i);
      if ((ab + i >= acc_q.size()) || (acc_q[ab+i] !== a)) e++;
      if ((pb + i >= pop_q.size()) || (pop_q[pb+i] !== exp_data(a))) e++;
    end
    return e;
  endfunction

  initial begin
    int b;
    int p;
    int d;
    int v;
    int r;
    int k;
    int e;
    reset_reset = 1'b1;
    go          = 1'b0;
    start_addr  = 32'd0;
    size_words  = 32'd0;
    st_ready    = 1'b1;
    tick(1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_read", 32'(avm_read), 32'd0);
    chk("rst_addr", avm_address, 32'd0);
    chk("rst_valid", 32'(st_valid), 32'd0);
    chk("rst_data", st_data, 32'd0);
    reset_reset = 1'b0;
    tick(2);

`ifdef FRAME_DMA_LOOP_EN
    d = n_done;
    b = acc_q.size();
    pulse_go(32'h0000_6000, 32'd4);
    v = busy_low;
    k = 0;
    while ((n_done - d < 3) && (k < 300)) begin
      tick(1);
      k++;
    end
    chk("loop_ndone", 32'(n_done - d), 32'd3);
    chk("loop_busy_never_low", 32'(busy_low - v), 32'd0);
    chk("loop_busy", 32'(busy), 32'd1);
    e = 0;
    for (int i = 0; i < 12; i++)
      if ((b + i >= acc_q.size()) || (acc_q[b+i] !== 32'h0000_6000 + 32'(4 * (i % 4)))) e++;
    chk("loop_addrs", 32'(e), 32'd0);
    reset_reset = 1'b1;
    tick(1);
    reset_reset = 1'b0;
    chk("loop_reset_busy", 32'(busy), 32'd0);
`else
    // Basic read: zero-wait slave, latency 2.
    b = acc_q.size();
    p = pop_q.size();
    d = n_done;
    pulse_go(32'h0000_1000, 32'd8);
    chk("basic_busy", 32'(busy), 32'd1);
    chk("basic_first_read", 32'(avm_read), 32'd1);
    chk("basic_first_addr", avm_address, 32'h0000_1000);
    wait_done("basic_done_timeout", d, 100);
    chk("basic_nacc", 32'(acc_q.size() - b), 32'd8);
    chk("basic_npop", 32'(pop_q.size() - p), 32'd8);
    chk("basic_sweep", 32'(sweep_err(b, p, 32'h0000_1000, 8)), 32'd0);
    chk("basic_done_busy_overlap", 32'(done_busy_err), 32'd0);
    chk("basic_ret_to_stream", 32'(first_vld_cyc - first_rdv_cyc), 32'd1);
    chk("basic_go_to_done", 32'(done_cyc - go_cyc), 32'd12);
    chk("basic_busy_after", 32'(busy), 32'd0);
    tick(3);
    chk("basic_one_done", 32'(n_done - d), 32'd1);

    // Zero-length start.
    b = acc_q.size();
    pulse_go(32'h0000_7000, 32'd0);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_busy", 32'(busy), 32'd0);
    chk("zero_read", 32'(avm_read), 32'd0);
    tick(1);
    chk("zero_done_pulse", 32'(done), 32'd0);
    chk("zero_go_to_done", 32'(done_cyc - go_cyc), 32'd1);
    chk("zero_nacc", 32'(acc_q.size() - b), 32'd0);

    // Back-pressure.
    st_ready = 1'b0;
    b = acc_q.size();
    p = pop_q.size();
    d = n_done;
    pulse_go(32'h0000_2000, 32'd40);
    tick(40);
    chk("bp_nacc_full", 32'(acc_q.size() - b), 32'd16);
    chk("bp_read_low", 32'(avm_read), 32'd0);
    chk("bp_valid", 32'(st_valid), 32'd1);
    st_ready = 1'b1;
    wait_done("bp_done_timeout", d, 300);
    chk("bp_nacc", 32'(acc_q.size() - b), 32'd40);
    chk("bp_npop", 32'(pop_q.size() - p), 32'd40);
    chk("bp_sweep", 32'(sweep_err(b, p, 32'h0000_2000, 40)), 32'd0);

    // Waitrequest held 3 cycles per request.
    ws = 3;
    b = acc_q.size();
    p = pop_q.size();
    d = n_done;
    pulse_go(32'h0000_3000, 32'd5);
    wait_done("ws_done_timeout", d, 200);
    ws = 0;
    chk("ws_stable", 32'(stable_err), 32'd0);
    chk("ws_nacc", 32'(acc_q.size() - b), 32'd5);
    chk("ws_sweep", 32'(sweep_err(b, p, 32'h0000_3000, 5)), 32'd0);

    // Address wrap.
    b = acc_q.size();
    p = pop_q.size();
    d = n_done;
    pulse_go(32'hFFFF_FFF8, 32'd4);
    wait_done("wrap_done_timeout", d, 100);
    chk("wrap_nacc", 32'(acc_q.size() - b), 32'd4);
    chk("wrap_addr2", acc_q[b+2], 32'h0000_0000);
    chk("wrap_sweep", 32'(sweep_err(b, p, 32'hFFFF_FFF8, 4)), 32'd0);

    // Misaligned base, plus a go while busy that must be ignored.
    b = acc_q.size();
    d = n_done;
    pulse_go(32'h0000_1003, 32'd2);
    chk("misalign_addr", avm_address, 32'h0000_1000);
    pulse_go(32'h0000_9000, 32'd3);
    wait_done("misalign_done_timeout", d, 100);
    tick(5);
    chk("ignore_go_nacc", 32'(acc_q.size() - b), 32'd2);
    chk("ignore_go_addr1", acc_q[b+1], 32'h0000_1004);
    chk("ignore_go_ndone", 32'(n_done - d), 32'd1);
    chk("ignore_go_busy", 32'(busy), 32'd0);

    // Reset with 3 reads outstanding (latency 6 so none has returned yet).
    lat_sel = 3'd5;
    b = acc_q.size();
    p = pop_q.size();
    r = n_rdv;
    pulse_go(32'h0000_4000, 32'd8);
    k = 0;
    while ((acc_q.size() - b < 3) && (k < 20)) begin
      tick(1);
      k++;
    end
    chk("mid_nacc", 32'(acc_q.size() - b), 32'd3);
    reset_reset = 1'b1;
    #1;
    v = vld_cnt;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_read", 32'(avm_read), 32'd0);
    chk("mid_rst_addr", avm_address, 32'd0);
    chk("mid_rst_valid", 32'(st_valid), 32'd0);
    chk("mid_rst_data", st_data, 32'd0);
    tick(2);
    reset_reset = 1'b0;
    tick(10);
    chk("mid_late_returns", 32'(n_rdv - r), 32'd3);
    chk("mid_no_valid", 32'(vld_cnt - v), 32'd0);
    chk("mid_no_pop", 32'(pop_q.size() - p), 32'd0);
    lat_sel = 3'd1;
    b = acc_q.size();
    p = pop_q.size();
    d = n_done;
    pulse_go(32'h0000_5000, 32'd3);
    wait_done("clean_done_timeout", d, 100);
    chk("clean_nacc", 32'(acc_q.size() - b), 32'd3);
    chk("clean_sweep", 32'(sweep_err(b, p, 32'h0000_5000, 3)), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
